mult_operand_ctrl: RTL and testbench

MULT_OPERAND_CTRL -- requirements
Module: mult_operand_ctrl

---
 rtl/mult_operand_ctrl.sv | 145 ++++++++++++++
 tb/tb_mult_operand_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_operand_ctrl.sv
// Operand loader and result capture for a pipelined multiplier.
// Two bouncing pushbuttons are synchronized and debounced. A press on
// key A loads mult_a from sw and a press on key B loads mult_b from sw.
// Either press (re)starts a wait of MULT_LATENCY edges, after which
// mult_y is captured into result.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   sw[15:0]              switch operand value (quasi-static)
//   key_load_a_n/_b_n     raw active-low pushbuttons
//   mult_a/mult_b[15:0]   registered operands to the multiplier
//   mult_y[31:0]          multiplier product
//   result[31:0]          captured product
//   result_valid          result matches current operands
//   busy                  computation in flight
//   result_count[7:0]     completed captures, wraps at 256
module mult_operand_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MULT_LATENCY    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw,
  input  logic        key_load_a_n,
  input  logic        key_load_b_n,
  output logic [15:0] mult_a,
  output logic [15:0] mult_b,
  input  logic [31:0] mult_y,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic [7:0]  result_count
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LAT_W = (MULT_LATENCY < 1) ? 1 : $clog2(MULT_LATENCY + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      sync_a;
  logic [1:0]      sync_b;
  logic [1:0]      key_s_c;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      db_lvl;
  logic [1:0]      db_lvl_q;
  logic [1:0]      ev_c;
  logic            any_ev_c;
  logic            capture_c;
  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [LAT_W-1:0] lat_cnt;

  // Two-flop synchronizers; idle level is released (1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 2'b11;
      sync_b <= 2'b11;
    end else begin
      sync_a <= {sync_a[0], key_load_a_n};
      sync_b <= {sync_b[0], key_load_b_n};
    end
  end

  assign key_s_c = {sync_b[1], sync_a[1]};

  // Independent debounce per key: level flips after DEBOUNCE_CYCLES differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      db_lvl   <= 2'b11;
      db_lvl_q <= 2'b11;
    end else begin
      db_lvl_q <= db_lvl;
      for (int i = 0; i < 2; i++) begin
        if (key_s_c[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] >= DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          db_lvl[i] <= key_s_c[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Press event: one-cycle pulse on a debounced 1->0 transition
  assign ev_c     = db_lvl_q & ~db_lvl;
  assign any_ev_c = |ev_c;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; an event always wins and restarts the wait
  always_comb begin
    state_nxt = state;
    capture_c = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (any_ev_c) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (any_ev_c) begin
          state_nxt = S_WAIT;
        end else if (lat_cnt == '0) begin
          state_nxt = S_DONE;
          capture_c = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand, latency counter and result datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_a       <= '0;
      mult_b       <= '0;
      lat_cnt      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      result_count <= '0;
      busy         <= 1'b0;
    end else begin
      busy <= (state_nxt == S_WAIT);
      if (ev_c[0]) mult_a <= sw;
      if (ev_c[1]) mult_b <= sw;
      if (any_ev_c) begin
        lat_cnt      <= LAT_W'(MULT_LATENCY);
        result_valid <= 1'b0;
      end else if (capture_c) begin
        result       <= mult_y;
        result_valid <= 1'b1;
        result_count <= result_count + 8'd1;
      end else if (state == S_WAIT) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mult_operand_ctrl.sv
// Self-checking bench for mult_operand_ctrl with a 5-stage multiplier model.
module tb_mult_operand_ctrl;

  localparam int unsigned DB  = 4;
  localparam int unsigned LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = '0;
  logic        ka = 1'b1;
  logic        kb = 1'b1;
  logic [15:0] mult_a;
  logic [15:0] mult_b;
  logic [31:0] mult_y;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;
  logic [7:0]  result_count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  exp_count = '0;

  mult_operand_ctrl #(.DEBOUNCE_CYCLES(DB), .MULT_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw),
    .key_load_a_n(ka), .key_load_b_n(kb),
    .mult_a(mult_a), .mult_b(mult_b), .mult_y(mult_y),
    .result(result), .result_valid(result_valid), .busy(busy),
    .result_count(result_count)
  );

  always #5 clk = ~clk;

  // Five-stage pipelined multiplier
  logic [31:0] pipe [5] = '{default: 32'h0};
  always @(posedge clk) begin
    pipe[0] <= {16'h0, mult_a} * {16'h0, mult_b};
    for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
  end
  assign mult_y = pipe[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    #2;
    vectors++;
    if ({mult_a, mult_b, result, result_valid, busy, result_count} !== 82'h0) begin
      miscompares++;
      $display("FAIL reset_async: got a=%h b=%h y=%h v=%b busy=%b cnt=%h, required all 0",
               mult_a, mult_b, result, result_valid, busy, result_count);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if ({mult_a, mult_b, result, result_valid, busy, result_count} !== 82'h0) begin
      miscompares++;
      $display("FAIL reset_idle: got a=%h b=%h y=%h v=%b busy=%b cnt=%h, required all 0",
               mult_a, mult_b, result, result_valid, busy, result_count);
    end
  endtask

  // A press then B press two edges later; the A computation is aborted by B
  task automatic run_op(input logic [15:0] a_val, input logic [15:0] b_val);
    logic [31:0] exp_y;
    logic [31:0] prev_res;
    bit          seen;
    exp_y    = 32'(a_val) * 32'(b_val);
    prev_res = result;
    seen     = 1'b0;
    @(negedge clk);
    sw = a_val;
    ka = 1'b0;
    repeat (2) @(negedge clk);
    kb = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL op_start: busy never rose for a=%h b=%h, required 1", a_val, b_val);
      ka = 1'b1;
      kb = 1'b1;
      repeat (20) @(negedge clk);
      return;
    end
    sw = b_val;
    repeat (2) @(negedge clk);
    vectors++;
    if ({mult_a, mult_b} !== {a_val, b_val}) begin
      miscompares++;
      $display("FAIL op_operands: got a=%h b=%h, required a=%h b=%h", mult_a, mult_b, a_val, b_val);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if ({busy, result_valid, result} !== {1'b1, 1'b0, prev_res}) begin
        miscompares++;
        $display("FAIL op_wait[%0d]: got busy=%b v=%b y=%h, required busy=1 v=0 y=%h",
                 i, busy, result_valid, result, prev_res);
      end
      @(negedge clk);
    end
    exp_count++;
    vectors++;
    if ({busy, result_valid, result, result_count} !== {1'b0, 1'b1, exp_y, exp_count}) begin
      miscompares++;
      $display("FAIL op_capture: got busy=%b v=%b y=%h cnt=%h, required busy=0 v=1 y=%h cnt=%h",
               busy, result_valid, result, result_count, exp_y, exp_count);
    end
    repeat (10) @(negedge clk);
    ka = 1'b1;
    kb = 1'b1;
    repeat (12) @(negedge clk);
    vectors++;
    if ({busy, result_valid, result, result_count} !== {1'b0, 1'b1, exp_y, exp_count}) begin
      miscompares++;
      $display("FAIL op_hold: got busy=%b v=%b y=%h cnt=%h, required busy=0 v=1 y=%h cnt=%h",
               busy, result_valid, result, result_count, exp_y, exp_count);
    end
  endtask

  task automatic test_basic;
    run_op(16'h1234, 16'h0010);
  endtask

  task automatic test_max;
    run_op(16'hFFFF, 16'hFFFF);
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) run_op(16'($urandom), 16'($urandom));
  endtask

  task automatic test_glitch;
    logic [15:0] mb;
    logic [31:0] res;
    mb  = mult_b;
    res = result;
    @(negedge clk);
    sw = ~mb;
    kb = 1'b0;
    repeat (3) @(negedge clk);
    kb = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if ({mult_b, busy, result_valid, result, result_count} !== {mb, 1'b0, 1'b1, res, exp_count}) begin
      miscompares++;
      $display("FAIL glitch: got b=%h busy=%b v=%b y=%h cnt=%h, required b=%h busy=0 v=1 y=%h cnt=%h",
               mult_b, busy, result_valid, result, result_count, mb, res, exp_count);
    end
  endtask

  // A=5 event at T (b=2 pending 0xA), B=3 event at T+3 restarts; 0xF at T+9
  task automatic test_abort;
    logic [31:0] prev_res;
    bit          seen;
    run_op(16'h0001, 16'h0002);
    prev_res = result;
    seen     = 1'b0;
    @(negedge clk);
    sw = 16'h0005;
    ka = 1'b0;
    repeat (3) @(negedge clk);
    kb = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL abort_start: busy never rose, required 1");
    end
    sw = 16'h0003;
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if ({busy, result_valid, result} !== {1'b1, 1'b0, prev_res}) begin
        miscompares++;
        $display("FAIL abort_wait[%0d]: got busy=%b v=%b y=%h, required busy=1 v=0 y=%h",
                 i, busy, result_valid, result, prev_res);
      end
      @(negedge clk);
    end
    exp_count++;
    vectors++;
    if ({mult_a, mult_b, result_valid, result, result_count} !==
        {16'h0005, 16'h0003, 1'b1, 32'h0000000F, exp_count}) begin
      miscompares++;
      $display("FAIL abort_capture: got a=%h b=%h v=%b y=%h cnt=%h, required a=0005 b=0003 v=1 y=0000000f cnt=%h",
               mult_a, mult_b, result_valid, result, result_count, exp_count);
    end
    ka = 1'b1;
    kb = 1'b1;
    repeat (15) @(negedge clk);
    vectors++;
    if ({busy, result, result_count} !== {1'b0, 32'h0000000F, exp_count}) begin
      miscompares++;
      $display("FAIL abort_once: got busy=%b y=%h cnt=%h, required busy=0 y=0000000f cnt=%h",
               busy, result, result_count, exp_count);
    end
  endtask

  task automatic test_reset_in_wait;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    sw = 16'h00AB;
    ka = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rstwait_start: busy never rose, required 1");
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({mult_a, mult_b, result, result_valid, busy, result_count} !== 82'h0) begin
      miscompares++;
      $display("FAIL rstwait_async: got a=%h b=%h y=%h v=%b busy=%b cnt=%h, required all 0",
               mult_a, mult_b, result, result_valid, busy, result_count);
    end
    ka = 1'b1;
    exp_count = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if ({mult_a, mult_b, result, result_valid, busy, result_count} !== 82'h0) begin
      miscompares++;
      $display("FAIL rstwait_nocapture: got a=%h b=%h y=%h v=%b busy=%b cnt=%h, required all 0",
               mult_a, mult_b, result, result_valid, busy, result_count);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 256; i++) run_op(16'($urandom), 16'($urandom));
    vectors++;
    if ({result_count, result_valid} !== {8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap: got cnt=%h v=%b, required cnt=00 v=1", result_count, result_valid);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_max;
    test_random;
    test_glitch;
    test_abort;
    test_reset_in_wait;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
